// File: rtl/imem_burst_ctrl_pkg.sv
// Shared encodings for the instruction-memory line-fill path.
// The cache side imports the same state codes and boolean constants.
package imem_burst_ctrl_pkg;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_ISSUE     = 2'd1;
  localparam logic [1:0] ST_DRAIN     = 2'd2;
  localparam logic [1:0] ST_WAIT_DROP = 2'd3;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

endpackage

// File: rtl/imem_beat_counter.sv
// Beat counter for one burst: clearable up-counter with a flag on the last beat index.
// It is one bit wider than the offset, so after the final beat it reads BURST_LEN
// instead of wrapping back to 0.
module imem_beat_counter #(
  parameter int BLOCK_OFFSET_WIDTH = 2
) (
  input  logic                          i_Clk,
  input  logic                          i_Reset_n,
  input  logic                          clear,
  input  logic                          enable,
  output logic [BLOCK_OFFSET_WIDTH:0]   count,
  output logic                          terminal
);

  localparam logic [BLOCK_OFFSET_WIDTH:0] LAST_IDX = {1'b0, {BLOCK_OFFSET_WIDTH{1'b1}}};

  // Clear has priority so a new burst always starts at beat 0.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n)  count <= '0;
    else if (clear)  count <= '0;
    else if (enable) count <= count + 1'b1;
  end

  assign terminal = (count == LAST_IDX);

endmodule

// File: rtl/imem_burst_ctrl.sv
// Line-fill engine. It takes one cache-line miss, issues BURST_LEN pipelined
// single-word reads, and returns the words in order as a registered beat stream.
// If the cache drops the request partway through, every outstanding read is still
// issued and drained, so memory ordering stays intact. The beats are suppressed.
module imem_burst_ctrl
  import imem_burst_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH         = 32,
  parameter int ADDR_WIDTH         = 21,
  parameter int BLOCK_OFFSET_WIDTH = 2
) (
  input  logic                  i_Clk,
  input  logic                  i_Reset_n,
  input  logic                  i_Req_Valid,
  input  logic [ADDR_WIDTH-1:0] i_Req_Address,
  output logic                  o_Resp_Valid,
  output logic                  o_Resp_Last,
  output logic [DATA_WIDTH-1:0] o_Resp_Data,
  output logic                  o_Mem_Read,
  output logic [ADDR_WIDTH-1:0] o_Mem_Address,
  input  logic                  i_Mem_WaitRequest,
  input  logic                  i_Mem_ReadDataValid,
  input  logic [DATA_WIDTH-1:0] i_Mem_ReadData,
  output logic                  o_Busy
);

  localparam int BOFF = BLOCK_OFFSET_WIDTH;

  logic [1:0]             state;
  logic [ADDR_WIDTH-BOFF-1:0] line;
  logic                   abort;
  logic [BOFF:0]          issue_cnt, ret_cnt;
  logic                   issue_term, ret_term;
  logic                   start, cmd_acc, ret_fire, abort_now;
  logic                   unused_bits;

  assign start     = (state == ST_IDLE) && i_Req_Valid;
  assign o_Mem_Read = (state == ST_ISSUE);
  assign cmd_acc   = o_Mem_Read && !i_Mem_WaitRequest;
  // Returns outside an active burst are protocol errors and are simply dropped.
  assign ret_fire  = i_Mem_ReadDataValid && ((state == ST_ISSUE) || (state == ST_DRAIN));
  // A beat returning in the same cycle the request falls is already unwanted.
  assign abort_now = abort || !i_Req_Valid;
  assign o_Busy    = (state != ST_IDLE);

  // The offset is concatenated onto the line, so the address never carries out of the line.
  assign o_Mem_Address = {line, issue_cnt[BOFF-1:0]};

  assign unused_bits = ^{i_Req_Address[BOFF-1:0], issue_cnt[BOFF], ret_cnt};

  imem_beat_counter #(.BLOCK_OFFSET_WIDTH(BOFF)) u_issue_cnt (
    .i_Clk     (i_Clk),
    .i_Reset_n (i_Reset_n),
    .clear     (start),
    .enable    (cmd_acc),
    .count     (issue_cnt),
    .terminal  (issue_term)
  );

  imem_beat_counter #(.BLOCK_OFFSET_WIDTH(BOFF)) u_ret_cnt (
    .i_Clk     (i_Clk),
    .i_Reset_n (i_Reset_n),
    .clear     (start),
    .enable    (ret_fire),
    .count     (ret_cnt),
    .terminal  (ret_term)
  );

  // Burst sequencing: accept, issue, drain, then wait for the cache to release the request.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state <= ST_IDLE;
      line  <= '0;
      abort <= FALSE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_Req_Valid) begin
            line  <= i_Req_Address[ADDR_WIDTH-1:BOFF];
            abort <= FALSE;
            state <= ST_ISSUE;
          end
        end
        ST_ISSUE, ST_DRAIN: begin
          if (!i_Req_Valid) abort <= TRUE;
          if (ret_fire && ret_term)
            state <= ST_WAIT_DROP;
          else if ((state == ST_ISSUE) && cmd_acc && issue_term)
            state <= ST_DRAIN;
        end
        ST_WAIT_DROP: begin
          // The request is still high in the cycle Last is presented, so it must not start a new fill.
          if (!i_Req_Valid) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Registered beat stream. A beat appears exactly one cycle after its memory return.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      o_Resp_Valid <= FALSE;
      o_Resp_Last  <= FALSE;
      o_Resp_Data  <= '0;
    end else begin
      o_Resp_Valid <= ret_fire && !abort_now;
      o_Resp_Last  <= ret_fire && ret_term && !abort_now;
      if (ret_fire) o_Resp_Data <= i_Mem_ReadData;
    end
  end

endmodule

// File: tb/tb_imem_burst_ctrl.sv
// Self-checking bench for imem_burst_ctrl: memory model with random latency/stalls,
// scenario tasks, and a beat-level expectation derived from request/return history.
module tb_imem_burst_ctrl;

  localparam int DW = 32, AW = 21, BOFF = 2, BL = 4;

  logic          i_Clk = 1'b0;
  logic          i_Reset_n = 1'b0;
  logic          i_Req_Valid = 1'b0;
  logic [AW-1:0] i_Req_Address = '0;
  logic          o_Resp_Valid, o_Resp_Last;
  logic [DW-1:0] o_Resp_Data;
  logic          o_Mem_Read;
  logic [AW-1:0] o_Mem_Address;
  logic          i_Mem_WaitRequest = 1'b0;
  logic          i_Mem_ReadDataValid = 1'b0;
  logic [DW-1:0] i_Mem_ReadData = '0;
  logic          o_Busy;

  imem_burst_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BLOCK_OFFSET_WIDTH(BOFF)) dut (
    .i_Clk(i_Clk), .i_Reset_n(i_Reset_n),
    .i_Req_Valid(i_Req_Valid), .i_Req_Address(i_Req_Address),
    .o_Resp_Valid(o_Resp_Valid), .o_Resp_Last(o_Resp_Last), .o_Resp_Data(o_Resp_Data),
    .o_Mem_Read(o_Mem_Read), .o_Mem_Address(o_Mem_Address),
    .i_Mem_WaitRequest(i_Mem_WaitRequest), .i_Mem_ReadDataValid(i_Mem_ReadDataValid),
    .i_Mem_ReadData(i_Mem_ReadData), .o_Busy(o_Busy)
  );

  always #5 i_Clk = ~i_Clk;

  int checks = 0, failures = 0, cyc = 0;

  // reference model state
  logic [AW-1:0] exp_base;
  int n_cmd, n_ret, beats_seen, last_due, lat_lo, lat_hi, wait_pct, stall_cmd, stall_left, overlaps;
  bit live, active, any_wait, exp_v, exp_l, prev_stall;
  logic [DW-1:0] exp_d;
  logic [AW-1:0] prev_addr;
  logic [AW-1:0] pend_addr[$];
  int pend_due[$];
  int cmd_cyc[BL];

  function automatic logic [DW-1:0] memword(input logic [AW-1:0] a);
    return 32'hC0DE0000 ^ ({11'b0, a} * 32'h9E3779B1);
  endfunction

  // One clock cycle: drive memory + request, check registered beat, log commands.
  task automatic run_cycle(input bit req, input logic [AW-1:0] addr);
    bit wr, rdv;
    logic [DW-1:0] rd;
    logic [AW-1:0] ra, ea;
    int due;
    i_Req_Valid = req;
    i_Req_Address = addr;
    wr = 1'b0;
    if (o_Mem_Read === 1'b1) begin
      if (n_cmd == stall_cmd && stall_left > 0) begin wr = 1'b1; stall_left--; end
      else if ($urandom_range(99) < wait_pct) wr = 1'b1;
    end
    if (wr) any_wait = 1'b1;
    i_Mem_WaitRequest = wr;
    rdv = 1'b0;
    rd = '0;
    if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
      rdv = 1'b1;
      ra = pend_addr.pop_front();
      void'(pend_due.pop_front());
      rd = memword(ra);
    end
    i_Mem_ReadDataValid = rdv;
    i_Mem_ReadData = rdv ? rd : $urandom();

    checks++;
    if (o_Resp_Valid !== exp_v) begin
      failures++;
      $display("FAIL resp_valid cyc=%0d got=%b want=%b", cyc, o_Resp_Valid, exp_v);
    end
    if (exp_v) begin
      checks++;
      if (o_Resp_Data !== exp_d) begin
        failures++;
        $display("FAIL resp_data cyc=%0d got=%h want=%h", cyc, o_Resp_Data, exp_d);
      end
    end
    checks++;
    if (o_Resp_Last !== exp_l) begin
      failures++;
      $display("FAIL resp_last cyc=%0d got=%b want=%b", cyc, o_Resp_Last, exp_l);
    end
    if (o_Resp_Valid === 1'b1) beats_seen++;

    if (prev_stall) begin
      checks++;
      if (o_Mem_Read !== 1'b1 || o_Mem_Address !== prev_addr) begin
        failures++;
        $display("FAIL stall_hold cyc=%0d got read=%b addr=%h want read=1 addr=%h",
                 cyc, o_Mem_Read, o_Mem_Address, prev_addr);
      end
    end
    prev_stall = (o_Mem_Read === 1'b1) && wr;
    prev_addr = o_Mem_Address;

    if (o_Mem_Read === 1'b1 && !wr) begin
      checks++;
      ea = exp_base + AW'(n_cmd);
      if (!active || n_cmd >= BL) begin
        failures++;
        $display("FAIL extra_cmd cyc=%0d got addr=%h want no command", cyc, o_Mem_Address);
      end else if (o_Mem_Address !== ea) begin
        failures++;
        $display("FAIL cmd_addr cyc=%0d got=%h want=%h", cyc, o_Mem_Address, ea);
      end
      if (n_cmd < BL) cmd_cyc[n_cmd] = cyc;
      if (rdv) overlaps++;
      due = cyc + int'($urandom_range(lat_hi, lat_lo));
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pend_addr.push_back(o_Mem_Address);
      pend_due.push_back(due);
      n_cmd++;
    end

    exp_v = 1'b0;
    exp_l = 1'b0;
    if (active) live = live && req;
    if (rdv && active) begin
      exp_v = live;
      exp_d = rd;
      exp_l = live && (n_ret == BL - 1);
      n_ret++;
    end
    @(posedge i_Clk);
    cyc++;
    @(negedge i_Clk);
  endtask

  task automatic begin_burst(input logic [AW-1:0] addr, input int llo, input int lhi,
                             input int wpct, input int scmd, input int scyc);
    exp_base = {addr[AW-1:BOFF], {BOFF{1'b0}}};
    lat_lo = llo; lat_hi = lhi; wait_pct = wpct; stall_cmd = scmd; stall_left = scyc;
    n_cmd = 0; n_ret = 0; beats_seen = 0; live = 1'b1; active = 1'b1;
    any_wait = 1'b0; overlaps = 0; prev_stall = 1'b0; last_due = cyc;
    pend_addr.delete(); pend_due.delete();
    checks++;
    if (o_Busy !== 1'b0 || o_Mem_Read !== 1'b0) begin
      failures++;
      $display("FAIL idle_before_req got busy=%b read=%b want 0 0", o_Busy, o_Mem_Read);
    end
    run_cycle(1'b1, addr);
    checks++;
    if (o_Mem_Read !== 1'b1 || o_Mem_Address !== exp_base) begin
      failures++;
      $display("FAIL first_cmd got read=%b addr=%h want read=1 addr=%h", o_Mem_Read, o_Mem_Address, exp_base);
    end
  endtask

  // Full fill. drop_after<0: no abort; tail_hold: cycles req stays high after the last return.
  task automatic do_burst(input logic [AW-1:0] addr, input int llo, input int lhi, input int wpct,
                          input int scmd, input int scyc, input int drop_after,
                          input int tail_hold, input logic [AW-1:0] tail_addr);
    int budget;
    bit dropped;
    begin_burst(addr, llo, lhi, wpct, scmd, scyc);
    budget = 0;
    dropped = 1'b0;
    while (n_ret < BL && budget < 200) begin
      if (drop_after >= 0 && beats_seen >= drop_after) dropped = 1'b1;
      run_cycle(!dropped, addr);
      budget++;
    end
    checks++;
    if (budget >= 200) begin
      failures++;
      $display("FAIL burst_timeout got returns=%0d want %0d", n_ret, BL);
    end
    checks++;
    if (n_cmd != BL) begin
      failures++;
      $display("FAIL cmd_count got=%0d want=%0d", n_cmd, BL);
    end
    if (!any_wait && n_cmd == BL) begin
      checks++;
      if (cmd_cyc[BL-1] - cmd_cyc[0] != BL - 1) begin
        failures++;
        $display("FAIL consecutive_cmds got span=%0d want %0d", cmd_cyc[BL-1] - cmd_cyc[0], BL - 1);
      end
    end
    for (int i = 0; i < tail_hold; i++) begin
      checks++;
      if (o_Busy !== 1'b1) begin
        failures++;
        $display("FAIL wait_drop_busy got=%b want=1", o_Busy);
      end
      run_cycle(1'b1, (i == 0) ? addr : tail_addr);
    end
    checks++;
    if (o_Busy !== 1'b1) begin
      failures++;
      $display("FAIL wait_drop_busy got=%b want=1", o_Busy);
    end
    run_cycle(1'b0, tail_addr);
    checks++;
    if (o_Busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_drop got busy=%b want 0", o_Busy);
    end
    checks++;
    if ((drop_after < 0 && beats_seen != BL) || (drop_after >= 0 && beats_seen >= BL)) begin
      failures++;
      $display("FAIL beat_count got=%0d want %s", beats_seen, (drop_after < 0) ? "4" : "<4");
    end
    active = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({o_Resp_Valid, o_Resp_Last, o_Resp_Data, o_Mem_Read, o_Mem_Address, o_Busy} !== '0) begin
      failures++;
      $display("FAIL %s got v=%b l=%b d=%h rd=%b a=%h busy=%b want all 0", name,
               o_Resp_Valid, o_Resp_Last, o_Resp_Data, o_Mem_Read, o_Mem_Address, o_Busy);
    end
  endtask

  task automatic test_reset();
    i_Reset_n = 1'b0;
    repeat (2) @(negedge i_Clk);
    check_all_zero("reset_state");
    i_Reset_n = 1'b1;
    @(negedge i_Clk);
    check_all_zero("idle_after_reset");
  endtask

  task automatic test_zero_wait();
    do_burst(21'h00013, 2, 2, 0, -1, 0, -1, 1, 21'h0);
  endtask

  task automatic test_stall();
    do_burst(21'h00013, 2, 2, 0, 1, 3, -1, 1, 21'h0);
  endtask

  task automatic test_same_cycle();
    do_burst(21'h00105, 1, 1, 0, -1, 0, -1, 1, 21'h0);
    checks++;
    if (overlaps != BL - 1) begin
      failures++;
      $display("FAIL same_cycle_overlap got=%0d want=%0d", overlaps, BL - 1);
    end
  endtask

  task automatic test_abort();
    do_burst(21'h00208, 3, 3, 0, -1, 0, 2, 0, 21'h0);
    do_burst(21'h00040, 2, 2, 0, -1, 0, -1, 1, 21'h0);
  endtask

  task automatic test_back_to_back();
    do_burst(21'h00300, 1, 3, 0, -1, 0, -1, 2, 21'h00020);
    do_burst(21'h00020, 1, 3, 0, -1, 0, -1, 1, 21'h0);
  endtask

  task automatic test_reset_mid_drain();
    int budget;
    begin_burst(21'h00035, 4, 4, 0, -1, 0);
    budget = 0;
    while (n_cmd < BL && budget < 50) begin
      run_cycle(1'b1, 21'h00035);
      budget++;
    end
    checks++;
    if (n_cmd != BL || n_ret >= BL) begin
      failures++;
      $display("FAIL drain_setup got cmds=%0d rets=%0d want 4 and <4", n_cmd, n_ret);
    end
    #2 i_Reset_n = 1'b0;
    #1 check_all_zero("async_reset_mid_drain");
    active = 1'b0; exp_v = 1'b0; exp_l = 1'b0;
    pend_addr.delete(); pend_due.delete();
    i_Req_Valid = 1'b0; i_Mem_ReadDataValid = 1'b0;
    @(negedge i_Clk);
    i_Reset_n = 1'b1;
    @(negedge i_Clk);
    pend_addr.push_back(21'h00035);
    pend_due.push_back(cyc);
    run_cycle(1'b0, 21'h0);
    run_cycle(1'b0, 21'h0);
    do_burst(21'h00035, 2, 2, 0, -1, 0, -1, 1, 21'h0);
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    for (int i = 0; i < 6; i++) begin
      a = AW'($urandom());
      do_burst(a, 1, 4, 30, -1, 0, (i == 3) ? int'($urandom_range(2)) : -1, 1, 21'h0);
    end
  endtask

  initial begin
    exp_v = 1'b0; exp_l = 1'b0; exp_d = '0; active = 1'b0; prev_stall = 1'b0;
    n_cmd = 0; n_ret = 0; stall_cmd = -1; stall_left = 0; wait_pct = 0; lat_lo = 1; lat_hi = 1;
    @(negedge i_Clk);
    test_reset();
    test_zero_wait();
    test_stall();
    test_same_cycle();
    test_abort();
    test_back_to_back();
    test_reset_mid_drain();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
